// File: rtl/load_data_unit.sv
// Load data unit: tracks issued loads in order, pairs each bus response with its record and
// delivers the byte/half/word-extracted, sign/zero-extended result through a registered output.
package load_data_unit_pkg;
    typedef logic [2:0] mem_t;
    localparam mem_t MEM_NONE = 3'd0;
    localparam mem_t MEM_LB   = 3'd1;
    localparam mem_t MEM_LBU  = 3'd2;
    localparam mem_t MEM_LH   = 3'd3;
    localparam mem_t MEM_LHU  = 3'd4;
    localparam mem_t MEM_LW   = 3'd5;
    localparam mem_t MEM_SB   = 3'd6;
    localparam mem_t MEM_SW   = 3'd7;
endpackage

module load_data_unit
    import load_data_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [1:0]               req_addr,
    input  mem_t                     req_type,
    output logic                     req_ready,
    input  logic                     flush,
    input  logic                     rsp_valid,
    input  logic [31:0]              rsp_data,
    output logic                     rsp_ready,
    output logic                     out_valid,
    output logic [31:0]              out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   outstanding
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [1:0]    r_addrMem [DEPTH];
    mem_t          r_typeMem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_discard;
    logic          r_outValid;
    logic [31:0]   r_outData;

    logic          w_full;
    logic          w_empty;
    logic          w_isLoad;
    logic          w_push;
    logic          w_pop;
    logic          w_discarding;
    logic [CW-1:0] w_countNext;
    logic [1:0]    w_headAddr;
    mem_t          w_headType;
    logic [15:0]   w_half;
    logic [7:0]    w_byte;
    logic [31:0]   w_ext;

    assign w_full       = (r_count == CW'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_isLoad     = (req_type == MEM_LW)  || (req_type == MEM_LH) || (req_type == MEM_LHU) ||
                          (req_type == MEM_LB)  || (req_type == MEM_LBU);
    assign w_push       = req_valid && !w_full && w_isLoad;
    assign w_discarding = (r_discard != '0);
    // A discarded response never reaches the output stage, so it need not wait for a drain.
    assign rsp_ready    = !w_empty && (w_discarding || !r_outValid || out_ready);
    assign w_pop        = rsp_valid && rsp_ready;

    assign req_ready    = !w_full;
    assign out_valid    = r_outValid;
    assign out_data     = r_outData;
    assign outstanding  = r_count;

    always_comb begin
        w_countNext = r_count;
        case ({w_push, w_pop})
            2'b10:   w_countNext = r_count + 1'b1;
            2'b01:   w_countNext = r_count - 1'b1;
            default: w_countNext = r_count;
        endcase
    end

    assign w_headAddr = r_addrMem[r_head];
    assign w_headType = r_typeMem[r_head];
    assign w_half     = w_headAddr[1] ? rsp_data[31:16] : rsp_data[15:0];

    always_comb begin
        w_byte = rsp_data[7:0];
        case (w_headAddr)
            2'd0: w_byte = rsp_data[7:0];
            2'd1: w_byte = rsp_data[15:8];
            2'd2: w_byte = rsp_data[23:16];
            2'd3: w_byte = rsp_data[31:24];
            default: w_byte = rsp_data[7:0];
        endcase
    end

    always_comb begin
        w_ext = rsp_data;
        case (w_headType)
            MEM_LH:  w_ext = {{16{w_half[15]}}, w_half};
            MEM_LHU: w_ext = {16'h0000, w_half};
            MEM_LB:  w_ext = {{24{w_byte[7]}}, w_byte};
            MEM_LBU: w_ext = {24'h000000, w_byte};
            default: w_ext = rsp_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addrMem[r_tail] <= req_addr;
            r_typeMem[r_tail] <= req_type;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            r_count <= w_countNext;
        end
    end

    // On flush every record still queued after this edge, including a same-cycle push, is stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_discard <= '0;
        end else if (flush) begin
            r_discard <= w_countNext;
        end else if (w_pop && w_discarding) begin
            r_discard <= r_discard - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
        end else if (flush) begin
            r_outValid <= 1'b0;
        end else if (w_pop && !w_discarding) begin
            r_outValid <= 1'b1;
            r_outData  <= w_ext;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_load_data_unit.sv
// Bench for load_data_unit: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-based behavioural model.
module tb_load_data_unit;
    import load_data_unit_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_addr;
    mem_t        req_type;
    logic        req_ready;
    logic        flush;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [$clog2(DEPTH):0] outstanding;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [1:0] a;
        mem_t       t;
    } rec_t;

    rec_t        q[$];
    int          discard;
    logic        expValid;
    logic [31:0] expData;

    load_data_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_type(req_type), .req_ready(req_ready),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .outstanding(outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit isLoad(input mem_t t);
        return (t == MEM_LW) || (t == MEM_LH) || (t == MEM_LHU) || (t == MEM_LB) || (t == MEM_LBU);
    endfunction

    function automatic logic [31:0] extract(input logic [1:0] a, input mem_t t, input logic [31:0] d);
        logic [31:0] v;
        int sh;
        v = d;
        if (t == MEM_LH || t == MEM_LHU) begin
            sh = a[1] ? 16 : 0;
            v = (d >> sh) & 32'h0000FFFF;
            if (t == MEM_LH && v >= 32'h00008000) v = v | 32'hFFFF0000;
        end else if (t == MEM_LB || t == MEM_LBU) begin
            sh = 8 * int'(a);
            v = (d >> sh) & 32'h000000FF;
            if (t == MEM_LB && v >= 32'h00000080) v = v | 32'hFFFFFF00;
        end
        return v;
    endfunction

    function automatic bit modelRspReady();
        return (q.size() > 0) && (discard > 0 || !expValid || out_ready);
    endfunction

    task automatic modelReset();
        q.delete();
        discard  = 0;
        expValid = 1'b0;
        expData  = '0;
    endtask

    task automatic checkLit(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares every DUT output against the model's view of the current cycle.
    task automatic checkOutput();
        checkLit("req_ready",   32'(req_ready),   32'(q.size() < DEPTH));
        checkLit("rsp_ready",   32'(rsp_ready),   32'(modelRspReady()));
        checkLit("outstanding", 32'(outstanding), 32'(q.size()));
        checkLit("out_valid",   32'(out_valid),   32'(expValid));
        if (expValid) checkLit("out_data", out_data, expData);
    endtask

    task automatic modelStep();
        bit          fire;
        bit          canPush;
        bit          wasDiscard;
        rec_t        r;
        logic [31:0] res;
        fire       = rsp_valid && modelRspReady();
        canPush    = req_valid && isLoad(req_type) && (q.size() < DEPTH);
        wasDiscard = (discard > 0);
        res        = '0;
        if (fire) begin
            r   = q.pop_front();
            res = extract(r.a, r.t, rsp_data);
        end
        if (canPush) begin
            r.a = req_addr;
            r.t = req_type;
            q.push_back(r);
        end
        if (flush) begin
            discard  = q.size();
            expValid = 1'b0;
        end else begin
            if (fire && wasDiscard) discard--;
            if (fire && !wasDiscard) begin
                expValid = 1'b1;
                expData  = res;
            end else if (out_ready) begin
                expValid = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [1:0] ra, input mem_t rt, input logic fl,
                                 input logic sv, input logic [31:0] sd, input logic ordy);
        req_valid = rv;
        req_addr  = ra;
        req_type  = rt;
        flush     = fl;
        rsp_valid = sv;
        rsp_data  = sd;
        out_ready = ordy;
        #1;
        checkOutput();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic doLoad(input logic [1:0] a, input mem_t t, input logic [31:0] d,
                          input logic [31:0] exp, input string name);
        applyStimulus(1'b1, a, t, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 2'd0, MEM_NONE, 1'b0, 1'b1, d, 1'b1);
        checkLit({name, "_valid"}, 32'(out_valid), 32'd1);
        checkLit(name, out_data, exp);
    endtask

    task automatic doReset();
        req_valid = 1'b0;
        flush     = 1'b0;
        rsp_valid = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        #1;
        modelReset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 2'd0;
        req_type  = MEM_NONE;
        flush     = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        out_ready = 1'b0;
        modelReset();
        #2;
        checkLit("rst_out_valid",   32'(out_valid),   32'd0);
        checkLit("rst_out_data",    out_data,         32'd0);
        checkLit("rst_outstanding", 32'(outstanding), 32'd0);
        checkLit("rst_req_ready",   32'(req_ready),   32'd1);
        checkLit("rst_rsp_ready",   32'(rsp_ready),   32'd0);
        @(negedge clk);
        reset = 1'b0;

        doLoad(2'd3, MEM_LB,  32'h80123456, 32'hFFFFFF80, "lb_a3");
        doLoad(2'd3, MEM_LBU, 32'h80123456, 32'h00000080, "lbu_a3");
        doLoad(2'd1, MEM_LB,  32'h80123456, 32'h00000034, "lb_a1");
        doLoad(2'd2, MEM_LH,  32'h80017FFF, 32'hFFFF8001, "lh_a2");
        doLoad(2'd0, MEM_LHU, 32'h80017FFF, 32'h00007FFF, "lhu_a0");
        doLoad(2'd0, MEM_LW,  32'h80017FFF, 32'h80017FFF, "lw");

        // Fill the record queue, then release one slot.
        repeat (4) applyStimulus(1'b1, 2'd0, MEM_LW, 1'b0, 1'b0, 32'h0, 1'b1);
        checkLit("full_outstanding", 32'(outstanding), 32'd4);
        checkLit("full_req_ready",   32'(req_ready),   32'd0);
        applyStimulus(1'b0, 2'd0, MEM_NONE, 1'b0, 1'b1, 32'hCAFE0001, 1'b1);
        checkLit("pop_outstanding", 32'(outstanding), 32'd3);
        checkLit("pop_req_ready",   32'(req_ready),   32'd1);
        checkLit("pop_out_data",    out_data,         32'hCAFE0001);

        // Back-pressure holds the output and blocks the response until the drain.
        applyStimulus(1'b0, 2'd0, MEM_NONE, 1'b0, 1'b1, 32'h12345678, 1'b0);
        checkLit("stall_rsp_ready", 32'(rsp_ready), 32'd0);
        checkLit("stall_out_data",  out_data,        32'hCAFE0001);
        out_ready = 1'b1;
        #1;
        checkLit("drain_rsp_ready", 32'(rsp_ready), 32'd1);
        #1;
        applyStimulus(1'b0, 2'd0, MEM_NONE, 1'b0, 1'b1, 32'h12345678, 1'b1);
        checkLit("refill_out_data", out_data, 32'h12345678);

        doReset();
        repeat (3) applyStimulus(1'b1, 2'd0, MEM_LW, 1'b0, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 2'd0, MEM_LW, 1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 2'd0, MEM_NONE, 1'b0, 1'b1, 32'hDEAD0000 + 32'(i), 1'b1);
            checkLit("flush_out_valid", 32'(out_valid), 32'd0);
        end
        checkLit("flush_outstanding", 32'(outstanding), 32'd0);
        doLoad(2'd2, MEM_LBU, 32'h00AB0000, 32'h000000AB, "post_flush");

        reset = 1'b1;
        #1;
        checkLit("midrst_out_valid",   32'(out_valid),   32'd0);
        checkLit("midrst_out_data",    out_data,         32'd0);
        checkLit("midrst_outstanding", 32'(outstanding), 32'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), mem_t'($urandom_range(0, 7)),
                          ($urandom_range(0, 99) < 3), 1'($urandom_range(0, 1)), $urandom,
                          ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
